// File: rtl/alu64_sequencer_pkg.sv
// Shared constants for the 64-bit ALU sequencer.
// Holds ALU op codes, request op encodings and FSM state codes.
package alu64_sequencer_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_ORR = 4'b1100;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_EOR = 3'b011;
    localparam logic [2:0] OP_ORR = 3'b100;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t S_IDLE = 2'd0;
    localparam seq_state_t S_LO   = 2'd1;
    localparam seq_state_t S_HI   = 2'd2;
    localparam seq_state_t S_RSP  = 2'd3;

    function automatic logic op_reserved(input logic [2:0] op);
        return op > OP_ORR;
    endfunction

    function automatic logic op_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu64_sequencer_if.sv
// Request/response handshake bundle for the 64-bit ALU sequencer.
// master = execute-stage requester, slave = sequencer.
interface alu64_sequencer_if #(
    parameter int WIDTH = 32
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_op;
    logic [2*WIDTH-1:0]   req_a;
    logic [2*WIDTH-1:0]   req_b;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   rsp_result;
    logic                 rsp_n;
    logic                 rsp_z;
    logic                 rsp_c;
    logic                 rsp_v;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result,
        input  rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result,
        output rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
    );

endinterface

// File: rtl/alu64_flag_merge.sv
// Combines the low-pass zero flag with the high-pass ALU flags
// into the 64-bit result word, NZCV and reserved-op error.
module alu64_flag_merge
    import alu64_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   res_lo,
    input  logic [WIDTH-1:0]   res_hi,
    input  logic               z_lo,
    input  logic               n_hi,
    input  logic               z_hi,
    input  logic               c_hi,
    input  logic               v_hi,
    output logic [2*WIDTH-1:0] result,
    output logic               n,
    output logic               z,
    output logic               c,
    output logic               v,
    output logic               err
);

    logic arith;

    always_comb begin
        err   = op_reserved(op);
        arith = op_arith(op);
        result = err ? '0 : {res_hi, res_lo};
        n = !err && n_hi;
        z = err || (z_lo && z_hi);
        // Carry/overflow only mean something for the add chain
        c = !err && arith && c_hi;
        v = !err && arith && v_hi;
    end

endmodule

// File: rtl/alu64_sequencer.sv
// Two-pass 64-bit ALU sequencer over a shared 32-bit ALU.
// Optional flush port enabled by defining ALU_SEQ_FLUSH_EN.
module alu64_sequencer
    import alu64_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ALU_SEQ_FLUSH_EN
    input  logic               flush,
`endif
    alu64_sequencer_if.slave   bus,
    output logic [3:0]         alu_op,
    output logic               alu_cin,
    output logic [WIDTH-1:0]   alu_src0,
    output logic [WIDTH-1:0]   alu_src1,
    input  logic [WIDTH-1:0]   alu_res,
    input  logic               alu_c,
    input  logic               alu_v,
    input  logic               alu_n,
    input  logic               alu_z
);

    logic               flush_w;
    seq_state_t         state;
    seq_state_t         state_nx;
    logic               accept;

    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] a_q;
    logic [2*WIDTH-1:0] b_q;
    logic [WIDTH-1:0]   res_lo;
    logic               carry_lo;
    logic               z_lo;

    logic               in_pass;
    logic               hi;
    logic [WIDTH-1:0]   a_w;
    logic [WIDTH-1:0]   b_w;

    logic [2*WIDTH-1:0] m_result;
    logic               m_n;
    logic               m_z;
    logic               m_c;
    logic               m_v;
    logic               m_err;

    logic [2*WIDTH-1:0] rsp_result_q;
    logic               rsp_n_q;
    logic               rsp_z_q;
    logic               rsp_c_q;
    logic               rsp_v_q;
    logic               rsp_err_q;

`ifdef ALU_SEQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign bus.req_ready = (state == S_IDLE) && !flush_w;
    assign bus.rsp_valid = (state == S_RSP);
    assign accept = bus.req_valid && bus.req_ready;

    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_n      = rsp_n_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_v      = rsp_v_q;
    assign bus.rsp_err    = rsp_err_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_LO;
            S_LO:    state_nx = S_HI;
            S_HI:    state_nx = S_RSP;
            S_RSP:   if (bus.rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush_w && state != S_IDLE) state_nx = S_IDLE;
    end

    // ALU drive depends only on state and latched operands
    assign in_pass = (state == S_LO) || (state == S_HI);
    assign hi      = (state == S_HI);
    assign a_w     = hi ? a_q[2*WIDTH-1:WIDTH] : a_q[WIDTH-1:0];
    assign b_w     = hi ? b_q[2*WIDTH-1:WIDTH] : b_q[WIDTH-1:0];

    always_comb begin
        alu_op   = ALU_AND;
        alu_cin  = 1'b0;
        alu_src0 = '0;
        alu_src1 = '0;
        if (in_pass) begin
            unique case (1'b1)
                (op_q == OP_ADD): begin
                    alu_op   = hi ? ALU_ADC : ALU_ADD;
                    alu_cin  = hi && carry_lo;
                    alu_src0 = a_w;
                    alu_src1 = b_w;
                end
                // a - b as a + ~b + 1, carry seeded on the low pass
                (op_q == OP_SUB): begin
                    alu_op   = ALU_ADC;
                    alu_cin  = hi ? carry_lo : 1'b1;
                    alu_src0 = a_w;
                    alu_src1 = ~b_w;
                end
                (op_q == OP_AND): begin
                    alu_op   = ALU_AND;
                    alu_src0 = a_w;
                    alu_src1 = b_w;
                end
                (op_q == OP_EOR): begin
                    alu_op   = ALU_EOR;
                    alu_src0 = a_w;
                    alu_src1 = b_w;
                end
                (op_q == OP_ORR): begin
                    alu_op   = ALU_ORR;
                    alu_src0 = a_w;
                    alu_src1 = b_w;
                end
                default: begin
                    alu_op   = ALU_AND;
                end
            endcase
        end
    end

    alu64_flag_merge #(
        .WIDTH (WIDTH)
    ) u_flag_merge (
        .op     (op_q),
        .res_lo (res_lo),
        .res_hi (alu_res),
        .z_lo   (z_lo),
        .n_hi   (alu_n),
        .z_hi   (alu_z),
        .c_hi   (alu_c),
        .v_hi   (alu_v),
        .result (m_result),
        .n      (m_n),
        .z      (m_z),
        .c      (m_c),
        .v      (m_v),
        .err    (m_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_lo       <= '0;
            carry_lo     <= 1'b0;
            z_lo         <= 1'b0;
            rsp_result_q <= '0;
            rsp_n_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_c_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
            end
            if (state == S_LO) begin
                res_lo   <= alu_res;
                carry_lo <= alu_c;
                z_lo     <= alu_z;
            end
            // High pass lands straight in the response registers
            if (state == S_HI && !flush_w) begin
                rsp_result_q <= m_result;
                rsp_n_q      <= m_n;
                rsp_z_q      <= m_z;
                rsp_c_q      <= m_c;
                rsp_v_q      <= m_v;
                rsp_err_q    <= m_err;
            end
        end
    end

endmodule
